// File: rtl/fp_pkg.sv
// Shared types and FP32 constants for the multiplier normalise/round stage.
package fp_pkg;

  // Operand special class as produced by the multiplier core.
  typedef enum logic [1:0] {
    FP_NORM = 2'b00,
    FP_ZERO = 2'b01,
    FP_INF  = 2'b10,
    FP_NAN  = 2'b11
  } fp_class_e;

  // Bit positions inside the 4-bit flag vector.
  localparam int unsigned FLAG_INVALID   = 3;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_INEXACT   = 0;

  // FP32 encoding constants.
  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG = {8'hFF, 23'h0};

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even plus exponent range and class handling.
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int unsigned ExpW = 11,
  parameter logic [31:0] Qnan = 32'h7FC0_0000
) (
  input  logic [23:0]            m_i,
  input  logic                   g_i,
  input  logic                   s_i,
  input  logic signed [ExpW-1:0] e_i,
  input  logic                   sign_i,
  input  fp_class_e              cls_i,
  output logic [31:0]            result_o,
  output logic [3:0]             flags_o
);

  localparam logic signed [ExpW-1:0] EMax  = ExpW'(EXP_MAX);
  localparam logic signed [ExpW-1:0] EZero = '0;

  logic                   round_up;
  logic [24:0]            mr;
  logic [22:0]            frac;
  logic signed [ExpW-1:0] e_adj;
  logic                   inexact;

  // Round, renormalise on mantissa carry-out, then apply range and class overrides.
  always_comb begin
    round_up = g_i & (s_i | m_i[0]);
    mr       = {1'b0, m_i} + {24'h0, round_up};
    frac     = mr[24] ? mr[23:1] : mr[22:0];
    e_adj    = e_i + $signed({{(ExpW-1){1'b0}}, mr[24]});
    inexact  = g_i | s_i;

    result_o = {sign_i, e_adj[7:0], frac};
    flags_o  = '0;
    flags_o[FLAG_INEXACT] = inexact;

    // Out-of-range results are never exact, so inexact is forced alongside.
    if (e_adj >= EMax) begin
      result_o = {sign_i, INF_MAG};
      flags_o  = '0;
      flags_o[FLAG_OVERFLOW] = 1'b1;
      flags_o[FLAG_INEXACT]  = 1'b1;
    end else if (e_adj <= EZero) begin
      result_o = {sign_i, 31'h0};
      flags_o  = '0;
      flags_o[FLAG_UNDERFLOW] = 1'b1;
      flags_o[FLAG_INEXACT]   = 1'b1;
    end

    unique case (cls_i)
      FP_ZERO: begin
        result_o = {sign_i, 31'h0};
        flags_o  = '0;
      end
      FP_INF: begin
        result_o = {sign_i, INF_MAG};
        flags_o  = '0;
      end
      FP_NAN: begin
        result_o = Qnan;
        flags_o  = '0;
        flags_o[FLAG_INVALID] = 1'b1;
      end
      FP_NORM: ;
    endcase
  end

endmodule

// File: rtl/fp_mul_round.sv
// FP32 multiplier back end: normalise stage, round/exception stage, sticky status.
module fp_mul_round #(
  parameter int unsigned EXP_W = 10,
  parameter logic [31:0] QNAN  = 32'h7FC0_0000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp_sum,
  input  logic [47:0]      in_mant,
  input  logic [1:0]       in_class,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_flags,
  output logic [3:0]       status,
  input  logic             status_clr
);
  import fp_pkg::*;

  logic en;
  logic hs;

  // Stage 1 state; exponent carries one extra bit for the normalise/round increments.
  logic                  s1_valid_q;
  logic [23:0]           s1_m_q, s1_m_d;
  logic                  s1_g_q, s1_g_d;
  logic                  s1_s_q, s1_s_d;
  logic signed [EXP_W:0] s1_e_q, s1_e_d;
  logic                  s1_sign_q;
  fp_class_e             s1_cls_q;

  // Stage 2 / output state.
  logic        out_valid_q;
  logic [31:0] out_result_q;
  logic [3:0]  out_flags_q;
  logic [31:0] rnd_result;
  logic [3:0]  rnd_flags;
  logic [3:0]  status_q, status_d;

  // Whole pipeline advances together whenever the output slot is free or draining.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign hs       = out_valid_q && out_ready;

  // Normalise: product is in [1,4), so a single-bit shift suffices.
  always_comb begin
    if (in_mant[47]) begin
      s1_m_d = in_mant[47:24];
      s1_g_d = in_mant[23];
      s1_s_d = |in_mant[22:0];
    end else begin
      s1_m_d = in_mant[46:23];
      s1_g_d = in_mant[22];
      s1_s_d = |in_mant[21:0];
    end
    s1_e_d = $signed({in_exp_sum[EXP_W-1], in_exp_sum}) + $signed({{EXP_W{1'b0}}, in_mant[47]});
  end

  // Stage 1 register: valid follows in_valid, payload loads only on an accepted beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_m_q     <= '0;
      s1_g_q     <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_e_q     <= '0;
      s1_sign_q  <= 1'b0;
      s1_cls_q   <= FP_NORM;
    end else if (en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_m_q    <= s1_m_d;
        s1_g_q    <= s1_g_d;
        s1_s_q    <= s1_s_d;
        s1_e_q    <= s1_e_d;
        s1_sign_q <= in_sign;
        s1_cls_q  <= fp_class_e'(in_class);
      end
    end
  end

  fp_round_rne #(
    .ExpW (EXP_W + 1),
    .Qnan (QNAN)
  ) u_round (
    .m_i      (s1_m_q),
    .g_i      (s1_g_q),
    .s_i      (s1_s_q),
    .e_i      (s1_e_q),
    .sign_i   (s1_sign_q),
    .cls_i    (s1_cls_q),
    .result_o (rnd_result),
    .flags_o  (rnd_flags)
  );

  // Stage 2 register: result and flags hold while stalled or on a bubble.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_result_q <= rnd_result;
        out_flags_q  <= rnd_flags;
      end
    end
  end

  // Sticky status: clear applies before the same-cycle handshake sets new bits.
  always_comb begin
    status_d = status_q;
    if (status_clr) status_d = '0;
    if (hs)         status_d = status_d | out_flags_q;
  end

  // Status register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) status_q <= '0;
    else         status_q <= status_d;
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign status     = status_q;

endmodule

// File: doc/fp_mul_round.md
Name: fp_mul_round

Overview:
- Downstream normalise/round/exception stage for the FP32 multiplier datapath.
- Consumes the raw 48-bit mantissa product, the pre-biased exponent sum, the sign and the operand special class from the multiplier core.
- Produces an IEEE-754 single-precision result, rounded to nearest-even, with per-result and sticky exception flags.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- EXP_W, 10: signed width of in_exp_sum. Covers the range -127..383.
- QNAN, 32'h7FC00000: canonical quiet NaN emitted for NaN results.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept an input beat this cycle.
- in_sign  in  1  result sign (X[31]^Y[31]).
- in_exp_sum  in  EXP_W  signed value expX+expY-127.
- in_mant  in  48  raw product {1,mX}*{1,mY}.
- in_class  in  2  special class: 00 normal, 01 zero, 10 inf, 11 nan. Upstream maps inf*0 and denormal inputs to nan/zero.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  32  FP32 result.
- out_flags  out  4  flags for this result: [3] invalid, [2] overflow, [1] underflow, [0] inexact.
- status  out  4  sticky OR of delivered flags.
- status_clr  in  1  synchronous clear of status.

Behaviour:
- Reset (resetn low, asynchronous): both stage valids, out_valid, out_result, out_flags and status go to 0. in_ready reads 1 after reset. Any beat in flight is discarded.
- Advance enable: en = !out_valid || out_ready. in_ready = en. Both stages load only when en is 1. A beat is accepted on in_valid && in_ready. Bubbles propagate as invalid.
- Latency: 2 cycles from acceptance to out_valid when unstalled. Throughput is 1 beat per cycle.
- While stalled (out_valid && !out_ready), out_result and out_flags hold stable. No beat is lost or duplicated, and order is preserved.
- Stage 1 (normalise, registered):
  - If in_mant[47]: m = in_mant[47:24], g = in_mant[23], s = |in_mant[22:0], e = exp_sum+1.
  - Else: m = in_mant[46:23], g = in_mant[22], s = |in_mant[21:0], e = exp_sum.
  - sign and class pass through.
- Stage 2 (round + exceptions, registered into the outputs):
  - Round up when g && (s || m[0]). mr = m + round up, 25 bits.
  - If mr[24] is set: e = e+1 and the fraction is mr[23:1]. Otherwise the fraction is mr[22:0].
  - inexact = g | s.
  - e >= 255: result is {sign, 8'hFF, 0}; flags are overflow|inexact.
  - e <= 0: flush to {sign, 31'b0}; flags are underflow|inexact. No denormal outputs are produced.
  - Otherwise: {sign, e[7:0], fraction}.
- Class override (takes priority over all of the above):
  - zero: {sign, 31'b0}, flags 0.
  - inf: {sign, 8'hFF, 0}, flags 0.
  - nan: QNAN, flags invalid only.
- status:
  - On each output handshake (out_valid && out_ready), status |= out_flags.
  - status_clr zeroes status.
  - If status_clr and a flagged handshake occur in the same cycle, the result is the new flags only (clear first, then set).

Decomposition:
- Package fp_pkg:
  - class enum (FP_NORM, FP_ZERO, FP_INF, FP_NAN).
  - flag bit indices.
  - FP32 constants: BIAS=127, EXP_MAX=255, QNAN, INF magnitude.
- One combinational sub-module, fp_round_rne: takes m/g/s/e/sign/class and returns result and flags. It is instantiated in stage 2.
- The top level holds the pipeline registers, the handshake logic and status.

Test Plan:
1. Basic 1.5*1.5: sign 0, exp_sum 127, mant 48'h900000000000, class normal → out_result 32'h40100000, flags 0, out_valid exactly 2 cycles after acceptance.
2. Tie to even: mant 48'h400000400000, exp_sum 127 → 32'h3F800000, flags inexact. Then mant 48'h400000C00000 → 32'h3F800002, flags inexact.
3. Rounding carry: mant 48'h7FFFFFC00000, exp_sum 127 → 32'h40000000, inexact.
4. Range limits:
   - exp_sum 254, mant 48'h800000000000, sign 0 → 32'h7F800000, flags overflow|inexact.
   - exp_sum 0, mant 48'h400000000000, sign 1 → 32'h80000000, flags underflow|inexact.
5. Backpressure:
   - Stimulus: three back-to-back beats, out_ready held low for 3 cycles after the first result.
   - Required: in_ready drops and out_result is held stable; all three results are delivered in order with none lost.
   - Then assert resetn low mid-stream: out_valid is 0 immediately and status is 0.
6. Specials/status:
   - class nan → 32'h7FC00000, flags invalid.
   - class inf with sign 1 → 32'hFF800000.
   - status accumulates 4'b1001 across beats.
   - status_clr in the same cycle as an overflow handshake → status = 4'b0101.
